// File: rtl/video_pkg.sv
// Shared types and constants for the video test-pattern generator.
package video_pkg;

  // Test patterns selectable through ctl_reg[2:1].
  typedef enum logic [1:0] {
    SOLID = 2'd0,
    BARS  = 2'd1,
    RAMP  = 2'd2,
    CHECK = 2'd3
  } pattern_e;

  // One 24-bit RGB pixel as carried on TDATA.
  typedef logic [23:0] pixel_t;

  // Coordinates handed to the colour mapper are zero-extended to this width
  // (4096 pixels/lines maximum).
  localparam int COORD_W = 12;

  // Control word field positions.
  localparam int CTL_EN_BIT  = 0;
  localparam int CTL_PAT_LSB = 1;
  localparam int CTL_COL_LSB = 8;

  // Colour-bar palette, left to right.
  localparam pixel_t BAR_WHITE   = 24'hFFFFFF;
  localparam pixel_t BAR_YELLOW  = 24'hFFFF00;
  localparam pixel_t BAR_CYAN    = 24'h00FFFF;
  localparam pixel_t BAR_GREEN   = 24'h00FF00;
  localparam pixel_t BAR_MAGENTA = 24'hFF00FF;
  localparam pixel_t BAR_RED     = 24'hFF0000;
  localparam pixel_t BAR_BLUE    = 24'h0000FF;
  localparam pixel_t BAR_BLACK   = 24'h000000;

  // Palette lookup by bar index.
  function automatic pixel_t bar_colour(input logic [2:0] idx);
    pixel_t c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_pattern_colour.sv
// Purely combinational mapping from pattern + position to an RGB pixel.
module video_pattern_colour
  import video_pkg::*;
(
  input  pattern_e             pattern_i,
  input  logic [COORD_W-1:0]   x_i,
  input  logic [COORD_W-1:0]   y_i,
  input  logic [2:0]           bar_idx_i,
  input  pixel_t               colour_i,
  output pixel_t               pixel_o
);

  // Only the low coordinate bits shape the patterns; the rest are ignored.
  logic unused_coord_bits;
  assign unused_coord_bits = ^{x_i[COORD_W-1:8], y_i[COORD_W-1:6], y_i[4:0]};

  // Select the pixel value for the requested pattern.
  always_comb begin
    pixel_o = '0;
    case (pattern_i)
      SOLID:   pixel_o = colour_i;
      BARS:    pixel_o = bar_colour(bar_idx_i);
      RAMP:    pixel_o = {x_i[7:0], x_i[7:0], x_i[7:0]};
      CHECK:   pixel_o = (x_i[5] ^ y_i[5]) ? 24'hFFFFFF : 24'h000000;
      default: pixel_o = '0;
    endcase
  end

endmodule

// File: rtl/video_pattern_gen.sv
// AXI4-Stream video test-pattern source: solid, colour bars, ramp, checker.
// Output registers always hold the pixel at (x_q, y_q); the next pixel is
// computed from the next-state coordinates and loaded on each handshake.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] ctl_reg,
  input  logic        m_axis_video_TREADY,
  output logic        m_axis_video_TVALID,
  output logic [23:0] m_axis_video_TDATA,
  output logic [2:0]  m_axis_video_TKEEP,
  output logic [2:0]  m_axis_video_TSTRB,
  output logic        m_axis_video_TUSER,
  output logic        m_axis_video_TLAST,
  output logic        m_axis_video_TID,
  output logic        m_axis_video_TDEST,
  output logic [15:0] frame_cnt
);

  localparam int XW    = $clog2(H_ACTIVE);
  localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BCW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [31:0]   ctl_sync_q, ctl_q;
  logic [0:0]    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [BCW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  pattern_e      pat_q, pat_d;
  pixel_t        colour_q, colour_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          tvalid_q, tvalid_d;
  pixel_t        tdata_q, tdata_d;
  logic          tuser_q, tuser_d;
  logic          tlast_q, tlast_d;

  logic          handshake, last_x, last_y;
  logic          start_frame, stop_frame, advance;
  pixel_t        pix_next;

  // Reserved control bits are synchronised along with the rest but unused.
  logic unused_ctl_bits;
  assign unused_ctl_bits = ^ctl_q[CTL_COL_LSB-1:CTL_PAT_LSB+2];

  assign handshake = tvalid_q && m_axis_video_TREADY;
  assign last_x    = (x_q == XW'(H_ACTIVE - 1));
  assign last_y    = (y_q == YW'(V_ACTIVE - 1));

  // Next position, bar tracking, frame settings latch and state transitions.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    bar_cnt_d   = bar_cnt_q;
    bar_idx_d   = bar_idx_q;
    pat_d       = pat_q;
    colour_d    = colour_q;
    frame_cnt_d = frame_cnt_q;
    start_frame = 1'b0;
    stop_frame  = 1'b0;
    advance     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctl_q[CTL_EN_BIT]) begin
          state_d     = ST_ACTIVE;
          pat_d       = pattern_e'(ctl_q[CTL_PAT_LSB +: 2]);
          colour_d    = ctl_q[CTL_COL_LSB +: 24];
          x_d         = '0;
          y_d         = '0;
          bar_cnt_d   = '0;
          bar_idx_d   = '0;
          start_frame = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (handshake) begin
          if (last_x && last_y) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            x_d         = '0;
            y_d         = '0;
            bar_cnt_d   = '0;
            bar_idx_d   = '0;
            if (ctl_q[CTL_EN_BIT]) begin
              // Settings only change on a frame boundary.
              pat_d       = pattern_e'(ctl_q[CTL_PAT_LSB +: 2]);
              colour_d    = ctl_q[CTL_COL_LSB +: 24];
              start_frame = 1'b1;
            end else begin
              state_d    = ST_IDLE;
              stop_frame = 1'b1;
            end
          end else begin
            advance = 1'b1;
            if (last_x) begin
              x_d       = '0;
              y_d       = y_q + 1'b1;
              bar_cnt_d = '0;
              bar_idx_d = '0;
            end else begin
              x_d = x_q + 1'b1;
              if (bar_cnt_q == BCW'(BAR_W - 1)) begin
                bar_cnt_d = '0;
                bar_idx_d = bar_idx_q + 1'b1;
              end else begin
                bar_cnt_d = bar_cnt_q + 1'b1;
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  video_pattern_colour u_colour (
    .pattern_i (pat_d),
    .x_i       (COORD_W'(x_d)),
    .y_i       (COORD_W'(y_d)),
    .bar_idx_i (bar_idx_d),
    .colour_i  (colour_d),
    .pixel_o   (pix_next)
  );

  // Output beat for the next position; held unchanged while stalled.
  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    if (start_frame) begin
      tvalid_d = 1'b1;
      tdata_d  = pix_next;
      tuser_d  = 1'b1;
      tlast_d  = 1'b0;
    end else if (stop_frame) begin
      tvalid_d = 1'b0;
      tdata_d  = '0;
      tuser_d  = 1'b0;
      tlast_d  = 1'b0;
    end else if (advance) begin
      tdata_d = pix_next;
      tuser_d = 1'b0;
      tlast_d = (x_d == XW'(H_ACTIVE - 1));
    end
  end

  // Register stage: control resync, counters, state and output beat.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ctl_sync_q  <= '0;
      ctl_q       <= '0;
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      bar_cnt_q   <= '0;
      bar_idx_q   <= '0;
      pat_q       <= SOLID;
      colour_q    <= '0;
      frame_cnt_q <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tuser_q     <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      ctl_sync_q  <= ctl_reg;
      ctl_q       <= ctl_sync_q;
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      bar_cnt_q   <= bar_cnt_d;
      bar_idx_q   <= bar_idx_d;
      pat_q       <= pat_d;
      colour_q    <= colour_d;
      frame_cnt_q <= frame_cnt_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
    end
  end

  assign m_axis_video_TVALID = tvalid_q;
  assign m_axis_video_TDATA  = tdata_q;
  assign m_axis_video_TUSER  = tuser_q;
  assign m_axis_video_TLAST  = tlast_q;
  assign m_axis_video_TKEEP  = {3{tvalid_q}};
  assign m_axis_video_TSTRB  = {3{tvalid_q}};
  assign m_axis_video_TID    = 1'b0;
  assign m_axis_video_TDEST  = 1'b0;
  assign frame_cnt           = frame_cnt_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen with a 16x4 frame.
module tb_video_pattern_gen;

  localparam int H = 16;
  localparam int V = 4;
  localparam int BEATS = H * V;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] ctl_reg;
  logic        tready;
  logic        tvalid;
  logic [23:0] tdata;
  logic [2:0]  tkeep, tstrb;
  logic        tuser, tlast, tid, tdest;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  logic        hold_q = 1'b0;
  logic [23:0] hold_data;
  logic        hold_user, hold_last;

  video_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .ctl_reg             (ctl_reg),
    .m_axis_video_TREADY (tready),
    .m_axis_video_TVALID (tvalid),
    .m_axis_video_TDATA  (tdata),
    .m_axis_video_TKEEP  (tkeep),
    .m_axis_video_TSTRB  (tstrb),
    .m_axis_video_TUSER  (tuser),
    .m_axis_video_TLAST  (tlast),
    .m_axis_video_TID    (tid),
    .m_axis_video_TDEST  (tdest),
    .frame_cnt           (frame_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference pixel for pattern/colour at (x, y).
  function automatic logic [23:0] exp_px(input int pat, input logic [23:0] col,
                                         input int x, input int y);
    logic [23:0] bars [8];
    logic [7:0]  xb;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    xb = 8'(x);
    case (pat)
      0:       return col;
      1:       return bars[x / (H / 8)];
      2:       return {xb, xb, xb};
      default: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  // Wait for one accepted beat (TREADY at duty%), checking content and stall stability.
  task automatic accept_beat(input int beat, input int pat, input logic [23:0] col,
                             input int duty);
    int x, y;
    logic done;
    x = beat % H;
    y = beat / H;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge aclk);
      if (hold_q) begin
        chk($sformatf("hold_tdata_b%0d", beat), 32'(tdata), 32'(hold_data));
        chk($sformatf("hold_tuser_b%0d", beat), 32'(tuser), 32'(hold_user));
        chk($sformatf("hold_tlast_b%0d", beat), 32'(tlast), 32'(hold_last));
      end
      tready = ($urandom_range(0, 99) < duty);
      if (tvalid && tready) begin
        chk($sformatf("tdata_b%0d", beat), 32'(tdata), 32'(exp_px(pat, col, x, y)));
        chk($sformatf("tuser_b%0d", beat), 32'(tuser), 32'(beat == 0));
        chk($sformatf("tlast_b%0d", beat), 32'(tlast), 32'(x == H - 1));
        chk($sformatf("tkeep_b%0d", beat), 32'(tkeep), 32'h7);
        hold_q = 1'b0;
        done = 1'b1;
      end else begin
        hold_q    = tvalid;
        hold_data = tdata;
        hold_user = tuser;
        hold_last = tlast;
      end
    end
    if (!done) chk($sformatf("timeout_b%0d", beat), 32'(done), 32'h1);
    $display("beat %0d x=%0d y=%0d tdata=%h tuser=%0b tlast=%0b", beat, x, y, tdata, tuser, tlast);
  endtask

  // One full frame; ctl_reg is rewritten before beat ctl_beat (if >= 0).
  task automatic run_frame(input int pat, input logic [23:0] col, input int duty,
                           input int ctl_beat, input logic [31:0] ctl_val);
    for (int b = 0; b < BEATS; b++) begin
      if (b == ctl_beat) ctl_reg = ctl_val;
      accept_beat(b, pat, col, duty);
    end
  endtask

  initial begin
    aresetn = 1'b0;
    ctl_reg = 32'h0;
    tready  = 1'b0;
    repeat (3) @(negedge aclk);

    // Reset state.
    chk("rst_tvalid", 32'(tvalid), 32'h0);
    chk("rst_tdata", 32'(tdata), 32'h0);
    chk("rst_tuser", 32'(tuser), 32'h0);
    chk("rst_tlast", 32'(tlast), 32'h0);
    chk("rst_tkeep", 32'(tkeep), 32'h0);
    chk("rst_tstrb", 32'(tstrb), 32'h0);
    chk("rst_tid", 32'(tid), 32'h0);
    chk("rst_tdest", 32'(tdest), 32'h0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'h0);

    // Enable solid colour: TVALID must rise exactly at the third edge.
    aresetn = 1'b1;
    ctl_reg = 32'h12345601;
    @(negedge aclk);
    chk("tvalid_edge1", 32'(tvalid), 32'h0);
    @(negedge aclk);
    chk("tvalid_edge2", 32'(tvalid), 32'h0);
    @(negedge aclk);
    chk("tvalid_edge3", 32'(tvalid), 32'h1);
    chk("first_tuser", 32'(tuser), 32'h1);
    chk("first_tdata", 32'(tdata), 32'h123456);

    // Frame 1 solid; switching to bars mid-frame must not disturb it.
    run_frame(0, 24'h123456, 100, 10, 32'h00000003);
    @(negedge aclk);
    chk("f1_frame_cnt", 32'(frame_cnt), 32'h1);
    chk("f1_b2b_tvalid", 32'(tvalid), 32'h1);
    chk("f1_b2b_tuser", 32'(tuser), 32'h1);
    tready = 1'b0;

    // Frame 2 bars, frame 3 bars with 30% ready; ramp requested during frame 3.
    run_frame(1, 24'h0, 100, -1, 32'h0);
    run_frame(1, 24'h0, 30, 10, 32'h00000005);
    // Frame 4 ramp; checker requested at beat 2 takes effect next frame.
    run_frame(2, 24'h0, 100, 2, 32'h00000007);
    // Frame 5 checker; enable cleared at beat 20, frame still completes.
    run_frame(3, 24'h0, 100, 20, 32'h00000006);
    @(negedge aclk);
    chk("stop_tvalid", 32'(tvalid), 32'h0);
    chk("stop_tkeep", 32'(tkeep), 32'h0);
    chk("stop_frame_cnt", 32'(frame_cnt), 32'h5);
    tready = 1'b0;

    // Restart, then reset mid-frame at beat 30.
    ctl_reg = 32'h12345601;
    for (int b = 0; b < 30; b++) accept_beat(b, 0, 24'h123456, 100);
    @(negedge aclk);
    aresetn = 1'b0;
    tready  = 1'b0;
    @(negedge aclk);
    chk("mrst_tvalid", 32'(tvalid), 32'h0);
    chk("mrst_tdata", 32'(tdata), 32'h0);
    chk("mrst_tuser", 32'(tuser), 32'h0);
    chk("mrst_tlast", 32'(tlast), 32'h0);
    chk("mrst_tkeep", 32'(tkeep), 32'h0);
    chk("mrst_tstrb", 32'(tstrb), 32'h0);
    chk("mrst_frame_cnt", 32'(frame_cnt), 32'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    hold_q  = 1'b0;

    // Fresh frame from x=0,y=0; enable dropped at beat 20.
    run_frame(0, 24'h123456, 100, 20, 32'h12345600);
    @(negedge aclk);
    chk("end_tvalid", 32'(tvalid), 32'h0);
    chk("end_frame_cnt", 32'(frame_cnt), 32'h1);
    tready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
